// File: rtl/asteroid_mover.sv
// Falling-asteroid game object: spawns at a pseudo-random column, drops one STEP per
// slow tick, and tracks hits, misses, lives and game over.
module asteroid_mover #(
    parameter int SCREEN_H   = 480,
    parameter int STEP       = 8,
    parameter int LIVES_INIT = 3
) (
    input  logic       clk_input,
    input  logic       rst_n,
    input  logic       tick_clk,
    input  logic       start,
    input  logic       hit,
    output logic [9:0] asteroid_x,
    output logic [8:0] asteroid_y,
    output logic       active,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        FALL,
        HIT,
        OVER
    } state_t;

    localparam logic [9:0] STEP10     = 10'(STEP);
    localparam logic [9:0] SCREEN10   = 10'(SCREEN_H);
    localparam logic [1:0] LIVES2     = 2'(LIVES_INIT);
    localparam logic [9:0] SPAWN_BASE = 10'd56;

    state_t     state_q, state_d;
    logic       tickMeta_q, tickSync_q, tickPrev_q;
    logic [1:0] armCnt_q;
    logic       tick;
    logic [9:0] lfsr_q;
    logic [9:0] asteroidX_q, asteroidX_d;
    logic [8:0] asteroidY_q, asteroidY_d;
    logic       active_q, active_d;
    logic [7:0] score_q, score_d;
    logic [1:0] lives_q, lives_d;
    logic       gameOver_q, gameOver_d;

    logic [9:0] spawnX;
    logic [9:0] yPlusStep;
    logic       atBottom;
    logic [7:0] scoreInc;
    logic [1:0] livesDec;

    // Edge detection stays disarmed until the synchronizer has settled after reset,
    // so a tick_clk already high at release is not mistaken for a rising edge.
    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            tickMeta_q <= 1'b0;
            tickSync_q <= 1'b0;
            tickPrev_q <= 1'b0;
            armCnt_q   <= 2'd0;
        end else begin
            tickMeta_q <= tick_clk;
            tickSync_q <= tickMeta_q;
            tickPrev_q <= tickSync_q;
            if (armCnt_q != 2'd3) begin
                armCnt_q <= armCnt_q + 2'd1;
            end
        end
    end

    assign tick = (armCnt_q == 2'd3) && tickSync_q && !tickPrev_q;

    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 10'h1;
        end else begin
            lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        end
    end

    assign spawnX    = {1'b0, lfsr_q[8:0]} + SPAWN_BASE;
    assign yPlusStep = {1'b0, asteroidY_q} + STEP10;
    assign atBottom  = (yPlusStep >= SCREEN10);
    assign scoreInc  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    assign livesDec  = lives_q - 2'd1;

    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            asteroidX_q <= 10'd0;
            asteroidY_q <= 9'd0;
            active_q    <= 1'b0;
            score_q     <= 8'd0;
            lives_q     <= LIVES2;
            gameOver_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            asteroidX_q <= asteroidX_d;
            asteroidY_q <= asteroidY_d;
            active_q    <= active_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            gameOver_q  <= gameOver_d;
        end
    end

    // A hit in FALL takes priority over a simultaneous bottom-reaching tick.
    always_comb begin
        state_d     = state_q;
        asteroidX_d = asteroidX_q;
        asteroidY_d = asteroidY_q;
        active_d    = active_q;
        score_d     = score_q;
        lives_d     = lives_q;
        gameOver_d  = gameOver_q;
        case (state_q)
            IDLE: begin
                active_d = 1'b0;
                if (start) begin
                    state_d = SPAWN;
                end
            end
            SPAWN: begin
                asteroidX_d = spawnX;
                asteroidY_d = 9'd0;
                active_d    = 1'b1;
                state_d     = FALL;
            end
            FALL: begin
                if (hit) begin
                    state_d  = HIT;
                    score_d  = scoreInc;
                    active_d = 1'b0;
                end else if (tick) begin
                    if (atBottom) begin
                        lives_d  = livesDec;
                        active_d = 1'b0;
                        if (livesDec == 2'd0) begin
                            state_d    = OVER;
                            gameOver_d = 1'b1;
                        end else begin
                            state_d = SPAWN;
                        end
                    end else begin
                        asteroidY_d = yPlusStep[8:0];
                    end
                end
            end
            HIT: begin
                if (tick) begin
                    state_d = SPAWN;
                end
            end
            OVER: begin
                gameOver_d = 1'b1;
                active_d   = 1'b0;
                if (start) begin
                    score_d    = 8'd0;
                    lives_d    = LIVES2;
                    gameOver_d = 1'b0;
                    state_d    = SPAWN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign asteroid_x = asteroidX_q;
    assign asteroid_y = asteroidY_q;
    assign active     = active_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign game_over  = gameOver_q;

endmodule

// File: doc/asteroid_mover.md
ASTEROID_MOVER -- requirements
Module: asteroid_mover

Interface
- REQ-001: Parameter SCREEN_H, default 480, meaning vertical pixel count; bottom boundary for a falling asteroid.
- REQ-002: Parameter STEP, default 8, meaning pixels moved per game tick.
- REQ-003: Parameter LIVES_INIT, default 3, meaning misses allowed before game over.
- REQ-004: clk_input  in  1  meaning system clock; all state is updated on its rising edge.
- REQ-005: rst_n  in  1  meaning asynchronous, active-low reset.
- REQ-006: tick_clk  in  1  meaning divided slow clock from the clock divider (10 Hz square wave); treated as asynchronous data.
- REQ-007: start  in  1  meaning level; begins or restarts a game.
- REQ-008: hit  in  1  meaning level; a laser collided with the asteroid in the current cycle.
- REQ-009: asteroid_x  out  10  meaning asteroid left-edge column.
- REQ-010: asteroid_y  out  9  meaning asteroid top-edge row.
- REQ-011: active  out  1  meaning asteroid is drawable.
- REQ-012: score  out  8  meaning hits this game.
- REQ-013: lives  out  2  meaning remaining lives.
- REQ-014: game_over  out  1  meaning the game has ended.

Function
- REQ-015: tick_clk SHALL pass through a 2-flop synchronizer, then rising-edge detect, to produce internal tick: exactly one clk_input cycle wide per tick_clk rising edge, asserted no later than the 3rd clk_input edge after the rising edge; falling edges produce no tick.
- REQ-016: A 10-bit Fibonacci LFSR (taps 10,7; seed 10'h1) SHALL advance every cycle and never reach all-zero.
- REQ-017: Spawn column SHALL be {1'b0, lfsr[8:0]} + 56, range 56..567.
- REQ-018: FSM states: IDLE, SPAWN, FALL, HIT, OVER.
- REQ-019: IDLE: active=0; on start -> SPAWN.
- REQ-020: SPAWN (1 cycle): latch asteroid_x from REQ-017; asteroid_y=0; active=1; -> FALL.
- REQ-021: FALL: on tick, if asteroid_y + STEP >= SCREEN_H (10-bit compare, no wrap), the asteroid is missed; otherwise asteroid_y += STEP.
- REQ-022: Miss: lives decrements; if lives becomes 0 -> OVER, else -> SPAWN; active=0 on the cycle after the miss.
- REQ-023: FALL and hit: -> HIT; score += 1, saturating at 255; active=0 on the next cycle.
- REQ-024: hit and a miss-tick in the same cycle: hit SHALL win; no life lost.
- REQ-025: hit outside FALL SHALL be ignored.
- REQ-026: HIT: wait for next tick, then -> SPAWN.
- REQ-027: OVER: game_over=1, active=0, position held; on start -> score=0, lives=LIVES_INIT, game_over=0, -> SPAWN.
- REQ-028: start in SPAWN, FALL or HIT SHALL be ignored.

Reset
- REQ-029: rst_n low SHALL force immediately, without a clock: state=IDLE, asteroid_x=0, asteroid_y=0, active=0, score=0, lives=LIVES_INIT, game_over=0, LFSR=10'h1, synchronizer/edge flops=0.
- REQ-030: Reset asserted mid-fall SHALL abandon the asteroid; after release the block waits in IDLE for start.
- REQ-031: No tick SHALL be generated on the first cycles after release, even if tick_clk is already high.

Verification
- REQ-032: Reset, start, 5 tick_clk rising edges -> active=1, asteroid_y=40, asteroid_x in 56..567, one y update per edge.
- REQ-033: Hold tick_clk high 100 cycles, then low -> exactly one y step; the falling edge causes no step.
- REQ-034: No hit, 60 ticks from spawn -> miss at the tick where y=472; lives 3->2, respawn at y=0; after 3 misses game_over=1 and lives=0.
- REQ-035: hit during FALL at y=80 -> score=1 and active=0 next cycle; respawn after the next tick; hit pulsed together with the miss-tick -> score+1, lives unchanged.
- REQ-036: Force score=255, then hit -> score stays 255; in OVER pulse start -> score=0, lives=3, game_over=0, SPAWN.
- REQ-037: Assert rst_n low asynchronously mid-FALL -> all outputs at reset values before the next clk_input edge.
